// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Streams a burst of words out of a synchronous-read BRAM onto a
//   valid/ready interface. The read-issue rate is limited by a credit check,
//   so the small output FIFO can never overflow.
//
// Ports
//   clock, resetn          : clock (rising edge), async active-low reset
//   start, base, len       : burst request (accepted only when idle)
//   busy, done             : burst in progress / one-cycle completion pulse
//   rdaddress, q           : BRAM read port (q valid RD_LAT cycles after issue)
//   out_data, out_valid,
//   out_ready, out_last    : output stream, out_last marks the final word
module bram_stream_reader #(
  parameter int AW     = 9,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int FDEPTH = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rdaddress,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);
  localparam int            PW   = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int            CW   = $clog2(FDEPTH + 1) + 1;
  localparam logic [CW-1:0] FD   = CW'(FDEPTH);
  localparam logic [PW-1:0] PMAX = PW'(FDEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              r_state;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       r_hold;
  logic [AW:0]         r_rem;
  logic                r_busy;
  logic                r_done;
  logic [RD_LAT-1:0]   r_vld_pipe;
  logic [RD_LAT-1:0]   r_last_pipe;

  logic [DW-1:0]       r_mem  [FDEPTH];
  logic                r_lmem [FDEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [CW-1:0]       r_cnt;

  logic [CW-1:0]       w_inflight;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // Credit: every issued read already owns a FIFO slot, counted as
  // in-flight until it lands and as buffered until it is popped.
  assign w_issue   = (r_state == RUN) && (r_rem != '0) && ((w_inflight + r_cnt) < FD);
  assign w_push    = r_vld_pipe[RD_LAT-1];
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid && out_ready;

  // Address goes out combinationally on issue so the BRAM samples it at the
  // same edge the issue is recorded; otherwise the last issued value holds.
  assign rdaddress = w_issue ? r_addr : r_hold;
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign out_last  = out_valid && r_lmem[r_rd];
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_hold      <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_done         <= 1'b0;
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_issue && (r_rem == (AW+1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      if (w_issue) begin
        r_hold <= r_addr;
        r_addr <= r_addr + AW'(1);   // wraps modulo 2^AW
        r_rem  <= r_rem - (AW+1)'(1);
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_addr  <= base;
              r_rem   <= len;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue && (r_rem == (AW+1)'(1))) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && out_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: out_data/out_last are gated by occupancy.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr]  <= q;
      r_lmem[r_wr] <= r_last_pipe[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: two instances (RD_LAT=1 and RD_LAT=2)
// share all inputs, each with its own BRAM model. Expected streams are the
// BRAM contents read from base upward modulo 512.
// Cycle index c counts negedge samples after the negedge that raises start,
// so c=1 is the cycle right after the edge that accepts start.
module tb_bram_stream_reader;
  localparam int AW = 9, DW = 32, FDEPTH = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;

  logic          busy1, done1, ov1, ol1, busy2, done2, ov2, ol2;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] q1, od1, q2, od2;
  logic [DW-1:0] qp2 [2];
  logic [DW-1:0] mem [512];

  int checks = 0, failures = 0;

  // burst recording
  logic [DW-1:0] d1_dat[$], d2_dat[$];
  logic          d1_lst[$], d2_lst[$];
  int            d1_cyc[$], d2_cyc[$];
  logic [AW-1:0] addr_q[$];
  int d1_done, d2_done, saw_busy, saw_valid, unstable, over;

  always #5 clock = ~clock;

  always @(posedge clock) q1 <= mem[ra1];
  always @(posedge clock) begin
    qp2[0] <= mem[ra2];
    qp2[1] <= qp2[0];
  end
  assign q2 = qp2[1];

  bram_stream_reader #(.AW(AW), .DW(DW), .RD_LAT(1), .FDEPTH(FDEPTH)) dut1 (
    .clock(clock), .resetn(resetn), .start(start), .base(base), .len(len),
    .busy(busy1), .done(done1), .rdaddress(ra1), .q(q1), .out_data(od1),
    .out_valid(ov1), .out_ready(out_ready), .out_last(ol1));

  bram_stream_reader #(.AW(AW), .DW(DW), .RD_LAT(2), .FDEPTH(FDEPTH)) dut2 (
    .clock(clock), .resetn(resetn), .start(start), .base(base), .len(len),
    .busy(busy2), .done(done2), .rdaddress(ra2), .q(q2), .out_data(od2),
    .out_valid(ov2), .out_ready(out_ready), .out_last(ol2));

  // Drives one burst and records what both instances produce. rs_at>0
  // re-pulses start (base 300, len 5) in that cycle while the burst runs.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l,
                           input int pct, input int max_cyc, input int rs_at);
    logic p_stall, p_lst;
    logic [DW-1:0] p_dat;
    logic [AW-1:0] p_addr;
    d1_dat.delete(); d1_lst.delete(); d1_cyc.delete();
    d2_dat.delete(); d2_lst.delete(); d2_cyc.delete(); addr_q.delete();
    d1_done = -1; d2_done = -1; saw_busy = 0; saw_valid = 0; unstable = 0; over = 0;
    p_stall = 1'b0; p_lst = 1'b0; p_dat = '0;
    @(negedge clock);
    start = 1'b1; base = b; len = l; out_ready = 1'b1; p_addr = ra1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clock);
      start = (c == rs_at);
      if (c == rs_at) begin base = AW'(300); len = (AW+1)'(5); end
      out_ready = ($urandom_range(99) < pct);
      if (busy1) saw_busy++;
      if (ov1) saw_valid++;
      if (ra1 != p_addr) begin addr_q.push_back(ra1); p_addr = ra1; end
      if (p_stall && (ov1 !== 1'b1 || od1 !== p_dat || ol1 !== p_lst)) unstable++;
      p_stall = ov1 && !out_ready; p_dat = od1; p_lst = ol1;
      if (int'(dut1.r_cnt) > FDEPTH) over++;
      if (ov1 && out_ready) begin d1_dat.push_back(od1); d1_lst.push_back(ol1); d1_cyc.push_back(c); end
      if (ov2 && out_ready) begin d2_dat.push_back(od2); d2_lst.push_back(ol2); d2_cyc.push_back(c); end
      if (done1 && d1_done < 0) d1_done = c;
      if (done2 && d2_done < 0) d2_done = c;
      if (d1_done >= 0 && d2_done >= 0) break;
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ov1); end
    checks++; if (ol1 !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", ol1); end
    checks++; if (ra1 !== '0) begin failures++; $display("FAIL reset_rdaddress got=%0d exp=0", ra1); end
    checks++; if (od1 !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", od1); end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 512; i++) mem[i] = DW'(i);
    run_burst(AW'(0), (AW+1)'(8), 100, 60, -1);
    checks++; if (d1_dat.size() != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", d1_dat.size()); end
    for (int k = 0; k < 8 && k < d1_dat.size(); k++) begin
      checks++;
      if (d1_dat[k] !== DW'(k) || d1_cyc[k] != 3 + k || d1_lst[k] !== (k == 7)) begin
        failures++;
        $display("FAIL basic_word%0d got=%0d@%0d last=%b exp=%0d@%0d last=%b", k, d1_dat[k], d1_cyc[k], d1_lst[k], k, 3 + k, k == 7);
      end
    end
    checks++; if (d1_done != 11) begin failures++; $display("FAIL basic_done got=%0d exp=11", d1_done); end
    checks++; if (d2_dat.size() != 8) begin failures++; $display("FAIL lat2_count got=%0d exp=8", d2_dat.size()); end
    for (int k = 0; k < 8 && k < d2_dat.size(); k++) begin
      checks++;
      if (d2_dat[k] !== DW'(k) || d2_cyc[k] != 4 + k || d2_lst[k] !== (k == 7)) begin
        failures++;
        $display("FAIL lat2_word%0d got=%0d@%0d last=%b exp=%0d@%0d last=%b", k, d2_dat[k], d2_cyc[k], d2_lst[k], k, 4 + k, k == 7);
      end
    end
    checks++; if (d2_done != 12) begin failures++; $display("FAIL lat2_done got=%0d exp=12", d2_done); end
  endtask

  task automatic test_wrap();
    run_burst(AW'(508), (AW+1)'(6), 100, 60, -1);
    checks++; if (addr_q.size() != 6) begin failures++; $display("FAIL wrap_addr_count got=%0d exp=6", addr_q.size()); end
    for (int k = 0; k < 6 && k < addr_q.size(); k++) begin
      checks++;
      if (int'(addr_q[k]) != (508 + k) % 512) begin
        failures++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", k, addr_q[k], (508 + k) % 512);
      end
    end
    checks++; if (d1_dat.size() != 6) begin failures++; $display("FAIL wrap_count got=%0d exp=6", d1_dat.size()); end
    for (int k = 0; k < 6 && k < d1_dat.size(); k++) begin
      checks++;
      if (d1_dat[k] !== DW'((508 + k) % 512) || d1_cyc[k] != 3 + k || d1_lst[k] !== (k == 5)) begin
        failures++; $display("FAIL wrap_word%0d got=%0d@%0d exp=%0d@%0d", k, d1_dat[k], d1_cyc[k], (508 + k) % 512, 3 + k);
      end
    end
  endtask

  task automatic test_stall();
    int b, l, e;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int it = 0; it < 4; it++) begin
      b = $urandom_range(511);
      l = (it == 0) ? 16 : $urandom_range(1, 40);
      run_burst(AW'(b), (AW+1)'(l), 50, 800, -1);
      checks++; if (d1_dat.size() != l) begin failures++; $display("FAIL stall%0d_count got=%0d exp=%0d", it, d1_dat.size(), l); end
      e = 0;
      for (int k = 0; k < l && k < d1_dat.size(); k++)
        if (d1_dat[k] !== mem[(b + k) % 512] || d1_lst[k] !== (k == l - 1)) e++;
      checks++; if (e != 0) begin failures++; $display("FAIL stall%0d_order bad_words=%0d exp=0", it, e); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL stall%0d_stable got=%0d exp=0", it, unstable); end
      checks++; if (over != 0) begin failures++; $display("FAIL stall%0d_occupancy got=%0d exp=0", it, over); end
      checks++; if (d1_done < 0) begin failures++; $display("FAIL stall%0d_done got=none exp=pulse", it); end
    end
  endtask

  task automatic test_len0();
    run_burst(AW'(42), (AW+1)'(0), 100, 20, -1);
    checks++; if (d1_done != 1) begin failures++; $display("FAIL len0_done got=%0d exp=1", d1_done); end
    checks++; if (saw_busy != 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", saw_busy); end
    checks++; if (saw_valid != 0 || d1_dat.size() != 0) begin failures++; $display("FAIL len0_valid got=%0d exp=0", saw_valid); end
  endtask

  task automatic test_start_busy();
    int e;
    run_burst(AW'(20), (AW+1)'(10), 100, 80, 3);
    checks++; if (d1_dat.size() != 10) begin failures++; $display("FAIL busy_start_count got=%0d exp=10", d1_dat.size()); end
    e = 0;
    for (int k = 0; k < 10 && k < d1_dat.size(); k++)
      if (d1_dat[k] !== mem[20 + k] || d1_lst[k] !== (k == 9)) e++;
    checks++; if (e != 0) begin failures++; $display("FAIL busy_start_order bad_words=%0d exp=0", e); end
    checks++; if (d2_dat.size() != 10) begin failures++; $display("FAIL busy_start_lat2 got=%0d exp=10", d2_dat.size()); end
  endtask

  task automatic test_reset_mid();
    int n, act;
    @(negedge clock);
    start = 1'b1; base = '0; len = (AW+1)'(10); out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (ov1) n++;
      if (n == 3) break;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL rstmid_progress got=%0d exp=3", n); end
    @(posedge clock); #2;
    resetn = 1'b0; #1;
    checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b/%b exp=0/0", ov1, ov2); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy1); end
    checks++; if (od1 !== '0 || ol1 !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%0h/%b exp=0/0", od1, ol1); end
    checks++; if (ra1 !== '0) begin failures++; $display("FAIL rstmid_rdaddress got=%0d exp=0", ra1); end
    @(negedge clock); resetn = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clock);
      if (ov1 || busy1 || done1 || ov2 || busy2) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", act); end
    run_burst(AW'(100), (AW+1)'(2), 100, 40, -1);
    checks++;
    if (d1_dat.size() != 2) begin
      failures++; $display("FAIL rstmid_restart_count got=%0d exp=2", d1_dat.size());
    end else if (d1_dat[0] !== mem[100] || d1_dat[1] !== mem[101] || d1_lst[0] !== 1'b0 || d1_lst[1] !== 1'b1) begin
      failures++; $display("FAIL rstmid_restart_data got=%0h,%0h exp=%0h,%0h", d1_dat[0], d1_dat[1], mem[100], mem[101]);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = DW'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_start_busy();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
